// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and constants for the matrix operand bank
//
// Purpose: FSM state encoding, default geometry and the fill-counter width
// helper used by matrix_mem_bank and mm_operand_ram.
package mm_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_N      = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } mm_state_e;

  // Counter must represent 0..n*n inclusive so "full" is a distinct value.
  function automatic int cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/mm_operand_ram.sv
// rtl/mm_operand_ram.sv - one N*N x DATA_W operand bank with fill pointer
//
// Purpose: serially loaded register bank; the write pointer doubles as the
// fill count. All entries are presented in parallel for column/row packing.
// Ports:
//   clk, clear_n     clock, asynchronous active-low reset
//   flush_i          synchronous clear of entries and count
//   we_i, data_i     write data_i at the current pointer (ignored when full)
//   clr_cnt_i        rewind the pointer to 0 without erasing entries
//   count_o, full_o  elements loaded, count == N*N
//   rd_data_o        entry e at [e*DATA_W +: DATA_W]
module mm_operand_ram
  import mm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  localparam int DEPTH = N * N,
  localparam int CNT_W = cnt_w(N)
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    flush_i,
  input  logic                    we_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    clr_cnt_i,
  output logic [CNT_W-1:0]        count_o,
  output logic                    full_o,
  output logic [DEPTH*DATA_W-1:0] rd_data_o
);

  logic [DEPTH*DATA_W-1:0] mem_q;
  logic [CNT_W-1:0]        cnt_q;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (we_i && !full_o) begin
      mem_q[int'(cnt_q)*DATA_W +: DATA_W] <= data_i;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_mem_bank.sv
// rtl/matrix_mem_bank.sv - W/X operand store streaming outer-product beats
//
// Purpose: holds one N x N weight matrix W and one N x N input matrix X, both
// loaded row-major. On start (both full, IDLE) it streams N registered beats;
// beat k carries W column k and X row k under a valid/ready handshake.
// Ports:
//   clk, clear_n          clock, asynchronous active-low reset
//   data_in, load_w/x     serial load (load_w wins when both asserted)
//   flush                 synchronous clear of banks, counts, flags, stream
//   start, keep_w         begin streaming; retain W at the final transfer
//   out_ready             consumer accepts the presented beat
//   w_full/x_full, w_count/x_count   fill status
//   busy, out_valid, out_last, w_col, x_row   stream side
//   ovf_err               sticky: load dropped because bank full or busy
module matrix_mem_bank
  import mm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  localparam int CNT_W = cnt_w(N)
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load_w,
  input  logic                load_x,
  input  logic                flush,
  input  logic                start,
  input  logic                keep_w,
  input  logic                out_ready,
  output logic                w_full,
  output logic                x_full,
  output logic [CNT_W-1:0]    w_count,
  output logic [CNT_W-1:0]    x_count,
  output logic                busy,
  output logic                out_valid,
  output logic                out_last,
  output logic [N*DATA_W-1:0] w_col,
  output logic [N*DATA_W-1:0] x_row,
  output logic                ovf_err
);

  localparam int DEPTH = N * N;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  logic [DEPTH*DATA_W-1:0] w_mem;
  logic [DEPTH*DATA_W-1:0] x_mem;
  logic                    w_we, x_we, w_clr, x_clr;

  mm_state_e            state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [N*DATA_W-1:0]  col_q, col_d;
  logic [N*DATA_W-1:0]  row_q, row_d;
  logic                 ovf_q, ovf_d;

  logic                 load_beat;
  logic [K_W-1:0]       load_k;
  logic                 idle;
  logic                 w_rej, x_rej;

  mm_operand_ram #(.DATA_W(DATA_W), .N(N)) u_w_ram (
    .clk       (clk),
    .clear_n   (clear_n),
    .flush_i   (flush),
    .we_i      (w_we),
    .data_i    (data_in),
    .clr_cnt_i (w_clr),
    .count_o   (w_count),
    .full_o    (w_full),
    .rd_data_o (w_mem)
  );

  mm_operand_ram #(.DATA_W(DATA_W), .N(N)) u_x_ram (
    .clk       (clk),
    .clear_n   (clear_n),
    .flush_i   (flush),
    .we_i      (x_we),
    .data_i    (data_in),
    .clr_cnt_i (x_clr),
    .count_o   (x_count),
    .full_o    (x_full),
    .rd_data_o (x_mem)
  );

  // Load acceptance and overflow. load_x is silently dropped when load_w is
  // also asserted; only its own rejection reasons raise ovf_err.
  always_comb begin
    idle  = (state_q == IDLE);
    w_we  = 1'b0;
    x_we  = 1'b0;
    w_rej = 1'b0;
    x_rej = 1'b0;
    if (!flush) begin
      w_we = idle && load_w && !w_full;
      x_we = idle && load_x && !load_w && !x_full;
    end
    w_rej = load_w && (!idle || w_full);
    x_rej = !load_w && load_x && (!idle || x_full);
    ovf_d = flush ? 1'b0 : (ovf_q | w_rej | x_rej);
  end

  // Stream FSM. Beat data is captured into output registers whenever a new
  // beat is presented; the banks cannot change while streaming since all
  // loads are rejected when busy.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    valid_d   = valid_q;
    last_d    = last_q;
    col_d     = col_q;
    row_d     = row_q;
    w_clr     = 1'b0;
    x_clr     = 1'b0;
    load_beat = 1'b0;
    load_k    = '0;

    unique case (state_q)
      IDLE: begin
        if (start && w_full && x_full) begin
          state_d   = STREAM;
          k_d       = '0;
          valid_d   = 1'b1;
          last_d    = (N == 1);
          load_beat = 1'b1;
          load_k    = '0;
        end
      end
      STREAM: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            col_d   = '0;
            row_d   = '0;
            x_clr   = 1'b1;
            w_clr   = !keep_w;
          end else begin
            k_d       = k_q + 1'b1;
            last_d    = ((k_q + 1'b1) == K_LAST);
            load_beat = 1'b1;
            load_k    = k_q + 1'b1;
          end
        end
      end
    endcase

    // Column of W: element (i, k); row of X: element (k, j), row-major index.
    if (load_beat) begin
      for (int i = 0; i < N; i++) begin
        col_d[i*DATA_W +: DATA_W] = w_mem[(i*N + int'(load_k))*DATA_W +: DATA_W];
        row_d[i*DATA_W +: DATA_W] = x_mem[(int'(load_k)*N + i)*DATA_W +: DATA_W];
      end
    end

    if (flush) begin
      state_d = IDLE;
      k_d     = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      col_d   = '0;
      row_d   = '0;
      w_clr   = 1'b0;
      x_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == STREAM);
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign w_col     = col_q;
  assign x_row     = row_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_matrix_mem_bank.sv
// tb/tb_matrix_mem_bank.sv - self-checking bench for matrix_mem_bank
module tb_matrix_mem_bank;

  localparam int DW = 4;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          load_w = 1'b0, load_x = 1'b0, flush = 1'b0;
  logic          start = 1'b0, keep_w = 1'b0, out_ready = 1'b0;
  logic          w_full, x_full, busy, out_valid, out_last, ovf_err;
  logic [CW-1:0] w_count, x_count;
  logic [N*DW-1:0] w_col, x_row;

  matrix_mem_bank #(.DATA_W(DW), .N(N)) dut (
    .clk(clk), .clear_n(clear_n), .data_in(data_in), .load_w(load_w),
    .load_x(load_x), .flush(flush), .start(start), .keep_w(keep_w),
    .out_ready(out_ready), .w_full(w_full), .x_full(x_full),
    .w_count(w_count), .x_count(x_count), .busy(busy), .out_valid(out_valid),
    .out_last(out_last), .w_col(w_col), .x_row(x_row), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: matrices as plain arrays, fill counts, sticky error.
  logic [DW-1:0] mw [NN];
  logic [DW-1:0] mx [NN];
  int            wc, xc;
  bit            movf, mbusy;

  logic [N*DW-1:0] got_col [N];
  logic [N*DW-1:0] got_row [N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] exp_col(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = mw[r*N + k];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_row(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = mx[k*N + c];
    return v;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < NN; e++) begin
      mw[e] = '0;
      mx[e] = '0;
    end
    wc = 0; xc = 0; movf = 0; mbusy = 0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic drive_load(input bit lw, input bit lx, input logic [DW-1:0] d);
    load_w = lw; load_x = lx; data_in = d;
    if (lw) begin
      if (!mbusy && wc < NN) begin mw[wc] = d; wc++; end
      else movf = 1;
    end else if (lx) begin
      if (!mbusy && xc < NN) begin mx[xc] = d; xc++; end
      else movf = 1;
    end
    tick();
    load_w = 1'b0; load_x = 1'b0;
  endtask

  task automatic load_seq(input bit is_w, input int first, input int step);
    int v;
    for (int e = 0; e < NN; e++) begin
      v = first + step * e;
      drive_load(is_w, !is_w, v[DW-1:0]);
    end
  endtask

  // Starts a stream and follows it to completion, checking every presented
  // beat against the model. stall_beat/stall_cycles holds out_ready low on a
  // chosen beat; otherwise out_ready is high with probability ready_pct.
  task automatic run_stream(input int ready_pct, input bit keep,
                            input int stall_beat, input int stall_cycles,
                            output int n_xfer, output int n_cyc);
    int k, hold;
    logic [N*DW+2:0] got, want;
    k = 0; hold = 0; n_cyc = 0;
    keep_w = keep;
    start = 1'b1;
    tick();
    start = 1'b0;
    mbusy = 1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: out_valid=%b want 1", out_valid);
    end
    while (k < N && n_cyc < 100) begin
      if (k == stall_beat && hold < stall_cycles) begin
        out_ready = 1'b0; hold++;
      end else if (ready_pct >= 100) out_ready = 1'b1;
      else out_ready = ($urandom_range(99) < ready_pct);
      got  = {out_valid, out_last, busy, w_col, x_row};
      want = {1'b1, (k == N - 1), 1'b1, exp_col(k), exp_row(k)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL beat%0d: got v/l/b=%b%b%b col=%h row=%h want %b%b%b col=%h row=%h",
                 k, out_valid, out_last, busy, w_col, x_row,
                 1'b1, (k == N - 1), 1'b1, exp_col(k), exp_row(k));
      end
      if (out_ready) begin
        got_col[k] = w_col;
        got_row[k] = x_row;
        k++;
      end
      tick();
      n_cyc++;
    end
    out_ready = 1'b0;
    keep_w = 1'b0;
    n_xfer = k;
    n_checks++;
    if (k != N) begin
      n_fail++;
      $display("FAIL stream_timeout: transfers=%0d want %0d", k, N);
    end
    mbusy = 0;
    xc = 0;
    if (!keep) wc = 0;
    n_checks++;
    if ({busy, out_valid, out_last} !== 3'b000 || w_count !== CW'(wc) || x_count !== CW'(xc)) begin
      n_fail++;
      $display("FAIL stream_end: busy=%b valid=%b last=%b wcnt=%0d xcnt=%0d want 0 0 0 %0d %0d",
               busy, out_valid, out_last, w_count, x_count, wc, xc);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({w_full, x_full, w_count, x_count, busy, out_valid, out_last, w_col, x_row, ovf_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wf=%b xf=%b wc=%0d xc=%0d busy=%b v=%b l=%b col=%h row=%h ovf=%b want all 0",
               w_full, x_full, w_count, x_count, busy, out_valid, out_last, w_col, x_row, ovf_err);
    end
    tick();
    clear_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_basic_stream();
    int nx, nc;
    logic [N*DW-1:0] ec [N];
    logic [N*DW-1:0] er [N];
    ec[0] = 12'h741; ec[1] = 12'h852; ec[2] = 12'h963;
    er[0] = 12'h789; er[1] = 12'h456; er[2] = 12'h123;
    do_flush();
    load_seq(1, 1, 1);
    load_seq(0, 9, -1);
    n_checks++;
    if ({w_full, x_full} !== 2'b11 || w_count !== CW'(NN) || x_count !== CW'(NN)) begin
      n_fail++;
      $display("FAIL load_full: wf=%b xf=%b wc=%0d xc=%0d want 1 1 9 9", w_full, x_full, w_count, x_count);
    end
    run_stream(100, 0, -1, 0, nx, nc);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (got_col[k] !== ec[k] || got_row[k] !== er[k]) begin
        n_fail++;
        $display("FAIL basic_beat%0d: col=%h row=%h want %h %h", k, got_col[k], got_row[k], ec[k], er[k]);
      end
    end
    n_checks++;
    if (nc != N) begin
      n_fail++;
      $display("FAIL basic_cycles: %0d want %0d", nc, N);
    end
  endtask

  task automatic test_backpressure();
    int nx, nc;
    do_flush();
    load_seq(1, 1, 1);
    load_seq(0, 9, -1);
    run_stream(100, 0, 1, 2, nx, nc);
    n_checks++;
    if (nx != 3 || nc != 5) begin
      n_fail++;
      $display("FAIL backpressure: transfers=%0d cycles=%0d want 3 5", nx, nc);
    end
  endtask

  task automatic test_overflow();
    int nx, nc;
    do_flush();
    load_seq(1, 1, 1);
    drive_load(1, 0, 4'hF);
    n_checks++;
    if (ovf_err !== 1'b1 || w_count !== CW'(NN)) begin
      n_fail++;
      $display("FAIL ovf_full: ovf=%b wc=%0d want 1 9", ovf_err, w_count);
    end
    load_seq(0, 9, -1);
    run_stream(100, 0, -1, 0, nx, nc);
    n_checks++;
    if (got_col[0] !== 12'h741 || got_col[2] !== 12'h963) begin
      n_fail++;
      $display("FAIL ovf_w_intact: col0=%h col2=%h want 741 963", got_col[0], got_col[2]);
    end
    do_flush();
    drive_load(1, 1, 4'h5);
    n_checks++;
    if (w_count !== CW'(1) || x_count !== '0 || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_load: wc=%0d xc=%0d ovf=%b want 1 0 0", w_count, x_count, ovf_err);
    end
  endtask

  task automatic test_keep_w();
    int nx, nc;
    do_flush();
    load_seq(1, 1, 1);
    load_seq(0, 9, -1);
    run_stream(100, 1, -1, 0, nx, nc);
    n_checks++;
    if (w_full !== 1'b1 || x_count !== '0) begin
      n_fail++;
      $display("FAIL keep_counts: wf=%b xc=%0d want 1 0", w_full, x_count);
    end
    load_seq(0, 1, 1);
    run_stream(100, 0, -1, 0, nx, nc);
    n_checks++;
    if (got_col[0] !== 12'h741 || got_col[1] !== 12'h852 || got_col[2] !== 12'h963 ||
        got_row[0] !== 12'h321 || got_row[1] !== 12'h654 || got_row[2] !== 12'h987) begin
      n_fail++;
      $display("FAIL keep_reuse: col=%h,%h,%h row=%h,%h,%h want 741,852,963 321,654,987",
               got_col[0], got_col[1], got_col[2], got_row[0], got_row[1], got_row[2]);
    end
  endtask

  task automatic test_start_ignored();
    do_flush();
    load_seq(1, 2, 1);
    for (int e = 0; e < NN - 1; e++) drive_load(0, 1, DW'(e));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 || x_count !== CW'(NN - 1)) begin
      n_fail++;
      $display("FAIL start_not_full: v=%b busy=%b ovf=%b xc=%0d want 0 0 0 8", out_valid, busy, ovf_err, x_count);
    end
  endtask

  task automatic test_flush_midstream();
    do_flush();
    load_seq(1, 3, 1);
    load_seq(0, 7, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    mbusy = 1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive_load(0, 1, 4'hA);
    n_checks++;
    if (ovf_err !== 1'b1 || x_count !== CW'(NN) || out_valid !== 1'b1 || w_col !== exp_col(1) || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_load: ovf=%b xc=%0d v=%b col=%h last=%b want 1 9 1 %h 0",
               ovf_err, x_count, out_valid, w_col, out_last, exp_col(1));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    n_checks++;
    if ({out_valid, out_last, busy, ovf_err, w_full, x_full} !== 6'b0 || w_count !== '0 || x_count !== '0) begin
      n_fail++;
      $display("FAIL flush_abort: v=%b l=%b busy=%b ovf=%b wc=%0d xc=%0d want all 0",
               out_valid, out_last, busy, ovf_err, w_count, x_count);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    load_seq(1, 1, 1);
    load_seq(0, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1 clear_n = 1'b0;
    #1;
    n_checks++;
    if ({w_full, x_full, w_count, x_count, busy, out_valid, out_last, w_col, x_row, ovf_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b v=%b wc=%0d xc=%0d col=%h row=%h want all 0",
               busy, out_valid, w_count, x_count, w_col, x_row);
    end
    tick();
    clear_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_random();
    int nx, nc, guard;
    bit kp;
    for (int it = 0; it < 4; it++) begin
      do_flush();
      guard = 0;
      while ((wc < NN || xc < NN || guard < 12) && guard < 300) begin
        drive_load($urandom_range(1), $urandom_range(1), DW'($urandom_range(15)));
        guard++;
        n_checks++;
        if (w_count !== CW'(wc) || x_count !== CW'(xc) || ovf_err !== movf) begin
          n_fail++;
          $display("FAIL rand_load it%0d: wc=%0d xc=%0d ovf=%b want %0d %0d %b",
                   it, w_count, x_count, ovf_err, wc, xc, movf);
        end
      end
      kp = $urandom_range(1);
      run_stream(60, kp, -1, 0, nx, nc);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_overflow();
    test_keep_w();
    test_start_ignored();
    test_flush_midstream();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_mem_bank.md
Name: matrix_mem_bank

Overview:
Parametrised operand store for the matrix multiplication accelerator. Holds one N x N weight matrix (W) and one N x N input matrix (X), both loaded serially in row-major order. Once both are full, a start pulse streams N beats in outer-product order to the MAC array: beat k carries W column k and X row k, under a valid/ready handshake. Unlike the previous bank, it adds fill tracking, overflow detection, synchronous flush, a streaming read-out FSM and optional weight reuse.

Parameters:
DATA_W, 4, element width in bits
N, 3, matrix dimension; each bank holds N*N elements
CNT_W, $clog2(N*N+1), width of the fill counters (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
data_in  in  DATA_W  element being loaded
load_w  in  1  write data_in to next W slot
load_x  in  1  write data_in to next X slot
flush  in  1  synchronous clear of both banks, counters and flags
start  in  1  begin streaming (honoured only when both banks are full and FSM is IDLE)
keep_w  in  1  sampled on the final beat; 1 retains W for reuse
out_ready  in  1  consumer accepts the current beat
w_full  out  1  W count == N*N
x_full  out  1  X count == N*N
w_count  out  CNT_W  W elements loaded
x_count  out  CNT_W  X elements loaded
busy  out  1  FSM in STREAM
out_valid  out  1  beat valid
out_last  out  1  high on beat N-1
w_col  out  N*DATA_W  W column k; element row i at [i*DATA_W +: DATA_W]
x_row  out  N*DATA_W  X row k; element column j at [j*DATA_W +: DATA_W]
ovf_err  out  1  sticky: a load was attempted while full or busy

Behaviour:
- Reset (clear_n=0, async): every memory entry = 0, counts = 0, FSM = IDLE. All outputs are 0.
- Storage: element e (0..N*N-1) maps to row e/N, column e%N. The e-th accepted load of a bank writes index e.
- Load, IDLE only: load_w is accepted when w_count < N*N; the element is written and w_count increments at the clock edge. load_x is handled the same way. If load_w and load_x are asserted together, load_w wins and load_x is dropped without setting ovf_err.
- Rejected load: a load to a full bank, or any load while busy, is dropped and sets ovf_err the next cycle.
- Flush has priority over everything except reset. One cycle later: memories = 0, counts = 0, ovf_err = 0, FSM = IDLE, out_valid = 0. A flush in mid-stream aborts the stream with no out_last.
- FSM:
  - IDLE -> STREAM on start && w_full && x_full. Otherwise start is ignored, with no error.
  - STREAM: beat index k starts at 0. Outputs are registered; out_valid rises the cycle after start is accepted (1-cycle latency).
  - A beat transfers when out_valid && out_ready. Outputs hold stable while out_valid && !out_ready. On transfer, k increments and the next beat is presented the following cycle, so back-to-back beats are possible.
  - Transfer of beat N-1 (out_last=1) -> IDLE, out_valid=0 next cycle. If keep_w=1 at that transfer, x_count = 0 and W is retained. If keep_w=0, both counts = 0. Memory contents are not erased in either case.
  - start while busy is ignored.
- busy = (state == STREAM). w_full/x_full are combinational from the counts.
- N=1 edge case: a single beat, with out_last=1 on it.

Decomposition:
- Shared package mm_pkg: state enum (IDLE, STREAM), the default DATA_W/N constants, and a CNT_W helper function.
- One sub-module, mm_operand_ram: a single N*N x DATA_W bank with write pointer, full flag and parallel read of all entries. It is instantiated twice.
- The top level holds the FSM, handshake and column/row packing.

Test Plan:
- N=3, DATA_W=4. Load W=1..9 and X=9..1, start with out_ready=1 -> beats of w_col/x_row are 12'h741/12'h789, 12'h852/12'h456, 12'h963/12'h123. out_last is high on beat 2; busy falls one cycle after beat 2.
- Same load, with out_ready low for 2 cycles on beat 1 -> beat 1 values hold for 3 cycles, and 3 transfers occur in total.
- After a full W, load_w=1 with data_in=4'hF -> ovf_err=1 and W is unchanged. Simultaneous load_w/load_x with W not full -> only w_count increments.
- Stream with keep_w=1 at the last beat -> w_full=1, x_count=0. Reload X=1..9 and start -> w_col is unchanged and x_row = 12'h321, 12'h654, 12'h987.
- start with x_count=8 -> no out_valid. flush in mid-stream (after beat 0) -> out_valid=0 next cycle and all counts 0. clear_n pulsed low while busy -> all outputs 0 immediately.
